// File: rtl/keypad_event_filter.sv
// Front end for the 4-button combination lock: synchronises and debounces the raw
// buttons, then turns each clean single-key press into one stretched one-hot event.
module keypad_event_filter #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_in,
    output logic [3:0] key_pulse,
    output logic [1:0] key_code,
    output logic       key_valid,
    output logic       multi_err
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PCW = $clog2(PULSE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_CYCLES);

    typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} state_e;

    function automatic logic [1:0] onehot_to_code(input logic [3:0] v);
        logic [1:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) c = 2'(i);
        end
        return c;
    endfunction

    logic [3:0]          meta_q, sync_q;
    logic [3:0]          deb_q, deb_d;
    logic [3:0][DCW-1:0] deb_cnt_q, deb_cnt_d;
    state_e              state_q, state_d;
    logic [3:0]          held_q, held_d;
    logic                launch, err;
    logic [3:0]          pulse_q, pulse_d;
    logic [1:0]          code_q, code_d;
    logic                valid_q, valid_d;
    logic [PCW-1:0]      pcnt_q, pcnt_d;
    logic                err_q;

    // NOTE: every piece of state is written with <= so all registers see the pre-edge values of each other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_in;
            sync_q <= meta_q;
        end
    end

    // NOTE: next-state values get a default first so no path leaves them unassigned (no latches).
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = ~deb_q[i];
                else                          deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
            end
        end
    end

    // NOTE: the counters are a packed vector, so one '0 clears them all on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        launch  = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb_q != '0) begin
                    if ($onehot(deb_q)) begin
                        launch  = 1'b1;
                        held_d  = deb_q;
                        state_d = HELD;
                    end else begin
                        err     = 1'b1;
                        state_d = LOCKOUT;
                    end
                end
            end
            HELD: begin
                if (deb_q == '0) begin
                    state_d = IDLE;
                end else if (deb_q != held_q) begin
                    err     = 1'b1;
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (deb_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A running stretch always finishes; a launch that lands during one is dropped.
    always_comb begin
        pulse_d = pulse_q;
        code_d  = code_q;
        valid_d = valid_q;
        pcnt_d  = pcnt_q;
        if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - PCW'(1);
            if (pcnt_q == PCW'(1)) begin
                pulse_d = '0;
                code_d  = '0;
                valid_d = 1'b0;
            end
        end else if (launch) begin
            pulse_d = deb_q;
            code_d  = onehot_to_code(deb_q);
            valid_d = 1'b1;
            pcnt_d  = PULSE_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            held_q  <= '0;
            pulse_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            pcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err;
        end
    end

    assign key_pulse = pulse_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign multi_err = err_q;

endmodule

// File: tb/tb_keypad_event_filter.sv
// Bench for keypad_event_filter: directed scenarios plus random button traffic,
// compared every cycle against a sample-history reference model.
module tb_keypad_event_filter;

    localparam int D = 4;
    localparam int P = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = 4'b0000;
    logic [3:0] key_pulse;
    logic [1:0] key_code;
    logic       key_valid;
    logic       multi_err;

    always #5 clk = ~clk;

    keypad_event_filter #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .key_pulse(key_pulse), .key_code(key_code),
        .key_valid(key_valid), .multi_err(multi_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sync is btn delayed two samples; a debounced bit flips once the
    // last D sync samples all disagree with it.
    logic [3:0] m_s1, m_s2, m_deb, m_held;
    logic [3:0] hist[$];
    int         mode;   // 0 idle, 1 holding a key, 2 locked out
    int         rem;
    logic [3:0] e_pulse;
    logic [1:0] e_code;
    logic       e_err;
    int         ev_cnt = 0, err_cnt = 0;
    logic       prev_valid = 1'b0;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_held = 0;
        hist.delete();
        mode = 0; rem = 0;
        e_pulse = 0; e_code = 0; e_err = 0;
    endtask

    task automatic model_step();
        logic [3:0] d;
        bit launch, err, all_diff;
        d = m_deb; launch = 0; err = 0;
        case (mode)
            0: if (d != 0) begin
                if ($countones(d) == 1) begin launch = 1; m_held = d; mode = 1; end
                else begin err = 1; mode = 2; end
            end
            1: if (d == 0) mode = 0;
               else if (d != m_held) begin err = 1; mode = 2; end
            default: if (d == 0) mode = 0;
        endcase
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin e_pulse = 0; e_code = 0; end
        end else if (launch) begin
            e_pulse = d; e_code = 2'($clog2(d)); rem = P;
        end
        e_err = err;
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1;
                foreach (hist[k]) if (hist[k][b] == m_deb[b]) all_diff = 0;
                if (all_diff) m_deb[b] = ~m_deb[b];
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        check("key_pulse", 32'(key_pulse), 32'(e_pulse));
        check("key_code",  32'(key_code),  32'(e_code));
        check("key_valid", 32'(key_valid), 32'(rem > 0));
        check("multi_err", 32'(multi_err), 32'(e_err));
        if (key_valid && !prev_valid) ev_cnt++;
        prev_valid = key_valid;
        if (multi_err) err_cnt++;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        btn_in = v;
        repeat (n) tick();
    endtask

    // Ticks until key_valid (want_err=0) or multi_err (want_err=1); -1 on timeout.
    task automatic count_until(input bit want_err, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((want_err && multi_err) || (!want_err && key_valid)) begin
                n = i;
                break;
            end
        end
    endtask

    int n, ev0, er0;

    initial begin
        model_reset();
        // 1. reset with all keys down, then release reset
        btn_in = 4'b1111;
        #2 rst = 1'b0;
        #1;
        check("rst_pulse", 32'(key_pulse), 0);
        check("rst_valid", 32'(key_valid), 0);
        repeat (3) tick();
        rst = 1'b1;
        ev0 = ev_cnt; er0 = err_cnt;
        count_until(1, n);
        check("err_latency", n, 7);
        hold(4'b1111, 6);
        hold(4'b0000, 12);
        check("s1_events", ev_cnt - ev0, 0);
        check("s1_errs", err_cnt - er0, 1);

        // 2. clean press
        ev0 = ev_cnt;
        btn_in = 4'b1000;
        count_until(0, n);
        check("press_latency", n, 7);
        check("press_code", 32'(key_code), 3);
        hold(4'b1000, 13);
        hold(4'b0000, 12);
        check("s2_events", ev_cnt - ev0, 1);

        // 3. bounce then settle; short glitch
        ev0 = ev_cnt;
        for (int i = 0; i < 8; i++) hold((i % 2 == 0) ? 4'b0001 : 4'b0000, 1);
        hold(4'b0001, 15);
        hold(4'b0000, 12);
        check("s3_bounce_events", ev_cnt - ev0, 1);
        ev0 = ev_cnt;
        hold(4'b0100, 3);
        hold(4'b0000, 12);
        check("s3_glitch_events", ev_cnt - ev0, 0);

        // 4. overlap
        ev0 = ev_cnt; er0 = err_cnt;
        hold(4'b0100, 12);
        hold(4'b0110, 10);
        hold(4'b0010, 10);
        check("s4_lockout_events", ev_cnt - ev0, 1);
        check("s4_errs", err_cnt - er0, 1);
        hold(4'b0000, 10);
        hold(4'b0010, 12);
        hold(4'b0000, 12);
        check("s4_events", ev_cnt - ev0, 2);

        // 5. sequence of four keys
        ev0 = ev_cnt;
        hold(4'b1000, 10); hold(4'b0000, 10);
        hold(4'b0001, 10); hold(4'b0000, 10);
        hold(4'b0100, 10); hold(4'b0000, 10);
        hold(4'b0010, 10); hold(4'b0000, 10);
        check("s5_events", ev_cnt - ev0, 4);

        // 6. reset in the middle of a stretch
        btn_in = 4'b0010;
        count_until(0, n);
        check("pre_rst_latency", n, 7);
        tick();
        #2 rst = 1'b0;
        #1;
        check("async_pulse", 32'(key_pulse), 0);
        check("async_code", 32'(key_code), 0);
        check("async_valid", 32'(key_valid), 0);
        model_reset();
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b1;
        count_until(0, n);
        check("post_rst_latency", n, 7);
        check("post_rst_pulse", 32'(key_pulse), 32'(4'b0010));
        hold(4'b0010, 5);
        hold(4'b0000, 12);

        // random traffic
        for (int s = 0; s < 40; s++) begin
            int r;
            logic [3:0] v;
            r = $urandom_range(0, 9);
            if (r < 5)      v = 4'(1 << $urandom_range(0, 3));
            else if (r < 7) v = 4'b0000;
            else            v = 4'($urandom_range(0, 15));
            hold(v, $urandom_range(1, 14));
        end
        hold(4'b0000, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
